// File: rtl/neander_spi_pkg.sv
// -----------------------------------------------------------------------------
// neander_spi_pkg
// Shared definitions for the peripheral SPI engine:
//   - spi_periph_state_t : engine FSM encoding (also driven on the debug port)
//   - CS_* constants     : fixed chip-select index map on cs_n
//   - SPI_BITS           : bits per transfer
// -----------------------------------------------------------------------------
package neander_spi_pkg;

  localparam int SPI_BITS = 8;

  // Chip-select index map (bit position in cs_n)
  localparam int CS_ADC   = 0;
  localparam int CS_DAC   = 1;
  localparam int CS_UART  = 2;
  localparam int CS_ETH   = 3;
  localparam int CS_GPIO  = 4;
  localparam int CS_FLASH = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUS = 3'd1,
    CS_SETUP = 3'd2,
    SHIFT    = 3'd3,
    CS_END   = 3'd4,
    DONE     = 3'd5
  } spi_periph_state_t;

endpackage

// File: rtl/spi_periph_engine_clk_divider.sv
// -----------------------------------------------------------------------------
// spi_clk_divider
// Reloadable down-counter style phase timer. tick_o is high for one cycle at
// the end of every (div_i+1)-cycle phase. clear_i restarts the phase so the
// first tick after a state change is exactly div_i+1 cycles later.
//
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   clear_i  restart the phase count (state entry / idle states)
//   div_i    phase length minus one
//   tick_o   last cycle of the current phase
// -----------------------------------------------------------------------------
module spi_clk_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Counting up to div_i is equivalent to reloading a down-counter with
  // div_i; the wrap on every tick is the reload at each phase change.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q >= div_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by clear_i: clear_i depends on the FSM next state, which
  // itself depends on this tick.
  assign tick_o = (cnt_q >= div_i);

endmodule

// File: rtl/spi_periph_engine.sv
// -----------------------------------------------------------------------------
// spi_periph_engine
// Byte-wide SPI master for the six peripheral chip selects on the shared SPI
// bus. Never starts a byte while the memory engine (mem_busy) owns the bus.
// All outputs are registered.
//
// Handshake: start is a single-cycle request. It is accepted only in a cycle
// where busy==0; tx_data, cs_sel, cs_hold and cfg_div are captured in that
// cycle and busy rises on the next cycle. A start while busy==1 is dropped,
// never queued. done pulses for one cycle with rx_data valid from that cycle.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               transfer request (see handshake above)
//   tx_data[7:0]        byte to send, MSB first
//   cs_sel[2:0]         chip-select index (>= NUM_CS: no CS, byte still clocked)
//   cs_hold             keep CS asserted after this byte
//   cfg_div[DIV_W-1:0]  SCLK half-period = cfg_div+1 clk cycles
//   mem_busy            memory engine owns the bus
//   miso                shared MISO
//   sclk, mosi, cs_n    SPI bus outputs
//   busy, done, rx_data status / result
//   dbg_state           current FSM state
//   cfg_mode[1:0]       {CPOL, CPHA}, only when SPI_PERIPH_MODE_EN is defined
//
// Build option: SPI_PERIPH_MODE_EN adds cfg_mode; without it the engine is
// SPI mode 0 only.
// -----------------------------------------------------------------------------
module spi_periph_engine
  import neander_spi_pkg::*;
#(
  parameter int NUM_CS = CS_FLASH + 1,
  parameter int DIV_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         tx_data,
  input  logic [2:0]         cs_sel,
  input  logic               cs_hold,
  input  logic [DIV_W-1:0]   cfg_div,
`ifdef SPI_PERIPH_MODE_EN
  input  logic [1:0]         cfg_mode,
`endif
  input  logic               mem_busy,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic [NUM_CS-1:0]  cs_n,
  output logic               busy,
  output logic               done,
  output logic [7:0]         rx_data,
  output spi_periph_state_t  dbg_state
);

  // Index of the last half-period in SHIFT, and the half-period index from
  // which the final (no-new-bit) trailing edge is entered.
  localparam logic [3:0] LAST_HALF     = 4'(2 * SPI_BITS - 1);
  localparam logic [3:0] LAST_TRAIL_PR = 4'(2 * SPI_BITS - 2);

  spi_periph_state_t state_q, state_d;

  logic [2:0]        sel_q, sel_d;
  logic              hold_q, hold_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        txsh_q, txsh_d;
  logic [7:0]        rxsh_q, rxsh_d;
  logic [3:0]        hcnt_q, hcnt_d;

  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rx_data_q, rx_data_d;

  logic              lead_edge;
  logic              trail_edge;
  logic              tick;
  logic              div_clear;

  // Clock mode: cpol/cpha are the latched mode, acc_cpol is the idle level
  // requested on the accept cycle (used when going straight to CS_SETUP).
  logic              cpol;
  logic              cpha;
  logic              acc_cpol;

`ifdef SPI_PERIPH_MODE_EN
  logic [1:0] mode_q, mode_d;
  assign cpol     = mode_q[1];
  assign cpha     = mode_q[0];
  assign acc_cpol = cfg_mode[1];
`else
  assign cpol     = 1'b0;
  assign cpha     = 1'b0;
  assign acc_cpol = 1'b0;
`endif

  // Active-low one-hot decode; out-of-range indices select nothing.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [2:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == 3'(i)) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  spi_clk_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (div_clear),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  // Phase timing only matters in CS_SETUP/SHIFT/CS_END; hold the counter at
  // zero elsewhere and restart it on every state change.
  assign div_clear = (state_d != state_q) || (state_q == IDLE) ||
                     (state_q == WAIT_BUS) || (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hold_d     = hold_q;
    div_d      = div_q;
    txsh_d     = txsh_q;
    rxsh_d     = rxsh_q;
    hcnt_d     = hcnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
`ifdef SPI_PERIPH_MODE_EN
    mode_d     = mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = cs_sel;
          hold_d = cs_hold;
          div_d  = cfg_div;
          txsh_d = tx_data;
          busy_d = 1'b1;
`ifdef SPI_PERIPH_MODE_EN
          mode_d = cfg_mode;
`endif
          if (mem_busy) begin
            state_d = WAIT_BUS;
            // A CS held for a different target is dropped now; the same
            // target stays low while we wait for the bus.
            if (cs_n_q != cs_decode(cs_sel)) begin
              cs_n_d = '1;
            end
          end else begin
            state_d = CS_SETUP;
            cs_n_d  = cs_decode(cs_sel);
            mosi_d  = tx_data[7];
            sclk_d  = acc_cpol;
          end
        end
      end

      WAIT_BUS: begin
        if (!mem_busy) begin
          state_d = CS_SETUP;
          cs_n_d  = cs_decode(sel_q);
          mosi_d  = txsh_q[7];
          sclk_d  = cpol;
        end
      end

      CS_SETUP: begin
        if (tick) begin
          state_d   = SHIFT;
          hcnt_d    = '0;
          lead_edge = 1'b1;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (hcnt_q == LAST_HALF) begin
            state_d = CS_END;
            if (!hold_q) begin
              cs_n_d = '1;
            end
          end else begin
            hcnt_d = hcnt_q + 4'd1;
            // hcnt_q odd -> entering an even index = odd half-period = leading
            if (hcnt_q[0]) begin
              lead_edge = 1'b1;
            end else begin
              trail_edge = 1'b1;
            end
          end
        end
      end

      CS_END: begin
        if (tick) begin
          state_d   = DONE;
          done_d    = 1'b1;
          rx_data_d = rxsh_q;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // CPHA=0: sample on leading, shift on trailing (none after the last bit).
    // CPHA=1: shift on leading, sample on trailing.
    if (lead_edge) begin
      sclk_d = ~cpol;
      if (cpha) begin
        mosi_d = txsh_q[7];
        txsh_d = {txsh_q[6:0], 1'b0};
      end else begin
        rxsh_d = {rxsh_q[6:0], miso};
      end
    end

    if (trail_edge) begin
      sclk_d = cpol;
      if (cpha) begin
        rxsh_d = {rxsh_q[6:0], miso};
      end else if (hcnt_q != LAST_TRAIL_PR) begin
        mosi_d = txsh_q[6];
        txsh_d = {txsh_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      hold_q    <= 1'b0;
      div_q     <= '0;
      txsh_q    <= '0;
      rxsh_q    <= '0;
      hcnt_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
`ifdef SPI_PERIPH_MODE_EN
      mode_q    <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      div_q     <= div_d;
      txsh_q    <= txsh_d;
      rxsh_q    <= rxsh_d;
      hcnt_q    <= hcnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
`ifdef SPI_PERIPH_MODE_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_data   = rx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_periph_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_periph_engine
// Directed scenarios for spi_periph_engine. Inputs are driven 1 ns after the
// rising edge; outputs are sampled at the same point, away from the edge.
// Expected received bytes go into exp_q when a transfer is launched and are
// popped when the DUT reports done.
// -----------------------------------------------------------------------------
module tb_spi_periph_engine;
  import neander_spi_pkg::*;

  localparam int NUM_CS = 6;
  localparam int DIV_W  = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic [7:0]        tx_data;
  logic [2:0]        cs_sel;
  logic              cs_hold;
  logic [DIV_W-1:0]  cfg_div;
  logic              mem_busy;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;
  logic              busy;
  logic              done;
  logic [7:0]        rx_data;
  spi_periph_state_t dbg_state;
`ifdef SPI_PERIPH_MODE_EN
  logic [1:0]        cfg_mode = 2'b00;
`endif

  spi_periph_engine #(
    .NUM_CS (NUM_CS),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tx_data   (tx_data),
    .cs_sel    (cs_sel),
    .cs_hold   (cs_hold),
    .cfg_div   (cfg_div),
`ifdef SPI_PERIPH_MODE_EN
    .cfg_mode  (cfg_mode),
`endif
    .mem_busy  (mem_busy),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Per-transfer observations, written only by the driver tasks below.
  int          cyc = 0;
  int          rises, done_cnt, done_cyc, cs_low_cnt, cs_rel;
  int          hi_min, hi_max, lo_min, lo_max, hi_len, lo_len;
  bit          lo_armed, loop_en;
  logic        prev_sclk;
  logic [5:0]  prev_cs, cs_and;
  logic [7:0]  mosi_cap, rx_got, pat;

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sclk && !prev_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
      if (lo_armed) begin
        if (lo_len < lo_min) lo_min = lo_len;
        if (lo_len > lo_max) lo_max = lo_len;
      end
      hi_len = 1;
    end else if (sclk) begin
      hi_len++;
    end else if (prev_sclk) begin
      if (hi_len < hi_min) hi_min = hi_len;
      if (hi_len > hi_max) hi_max = hi_len;
      lo_len   = 1;
      lo_armed = 1'b1;
    end else begin
      lo_len++;
    end
    prev_sclk = sclk;
    cs_and = cs_and & cs_n;
    if (cs_n != '1) cs_low_cnt++;
    if (cs_n == '1 && prev_cs != '1) cs_rel++;
    prev_cs = cs_n;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      rx_got   = rx_data;
    end
    // Peripheral model: loopback, or a fixed byte presented MSB first and
    // advanced after each rising sclk.
    if (loop_en) miso = mosi;
    else         miso = (rises < 8) ? pat[7 - rises] : 1'b0;
  endtask

  task automatic clear_stats(input bit loop, input logic [7:0] p);
    rises      = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    cs_low_cnt = 0;
    hi_min     = 9999;
    hi_max     = 0;
    lo_min     = 9999;
    lo_max     = 0;
    hi_len     = 0;
    lo_len     = 0;
    lo_armed   = 1'b0;
    cs_and     = '1;
    mosi_cap   = '0;
    loop_en    = loop;
    pat        = p;
    prev_sclk  = sclk;
    prev_cs    = cs_n;
    miso       = loop ? mosi : p[7];
  endtask

  // Drive a one-cycle start; t returns the cycle number of the accept cycle.
  task automatic kick(input logic [7:0] tx, input logic [2:0] sel,
                      input logic hold, input logic [7:0] div, output int t);
    tx_data = tx;
    cs_sel  = sel;
    cs_hold = hold;
    cfg_div = div;
    start   = 1'b1;
    t       = cyc;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) step();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (sclk !== 1'b0)       begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)       begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (cs_n !== 6'h3F)      begin n_bad++; $display("FAIL reset_cs_n: got %h want 3f", cs_n); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rx_data !== 8'h00)   begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    n_cmp++; if (dbg_state !== IDLE)  begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int t;
    logic [7:0] e;
    clear_stats(1'b1, 8'h00);
    exp_q.push_back(8'hA5);
    kick(8'hA5, 3'd2, 1'b0, 8'd0, t);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(200);
    e = exp_q.pop_front();
    n_cmp++; if (done_cyc - t !== 19)       begin n_bad++; $display("FAIL basic_latency: got %0d want 19", done_cyc - t); end
    n_cmp++; if (rx_got !== e)              begin n_bad++; $display("FAIL basic_rx: got %h want %h", rx_got, e); end
    n_cmp++; if (rises !== 8)               begin n_bad++; $display("FAIL basic_rises: got %0d want 8", rises); end
    n_cmp++; if (mosi_cap !== 8'hA5)        begin n_bad++; $display("FAIL basic_mosi: got %h want a5", mosi_cap); end
    n_cmp++; if (cs_and !== 6'b111011)      begin n_bad++; $display("FAIL basic_cs: got %b want 111011", cs_and); end
    n_cmp++; if (cs_low_cnt !== 17)         begin n_bad++; $display("FAIL basic_cs_len: got %0d want 17", cs_low_cnt); end
    step();
    step();
    n_cmp++; if (cs_n !== 6'h3F)            begin n_bad++; $display("FAIL basic_cs_after: got %h want 3f", cs_n); end
    n_cmp++; if (busy !== 1'b0)             begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_wait_bus();
    int t;
    int f;
    int bad;
    logic [7:0] e;
    clear_stats(1'b1, 8'h00);
    bad = 0;
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (cs_n !== 6'h3F || sclk !== 1'b0) bad++;
    end
    exp_q.push_back(8'h5C);
    kick(8'h5C, 3'd0, 1'b0, 8'd1, t);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy: got %b want 1", busy); end
    for (int k = 0; k < 6; k++) begin
      if (cs_n !== 6'h3F || sclk !== 1'b0 || dbg_state !== WAIT_BUS) bad++;
      step();
    end
    if (cs_n !== 6'h3F || sclk !== 1'b0 || dbg_state !== WAIT_BUS) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL wait_hold_bus: got %0d bad cycles want 0", bad); end
    mem_busy = 1'b0;
    f = cyc;
    step();
    n_cmp++; if (cs_n !== 6'b111110) begin n_bad++; $display("FAIL wait_cs_setup: got %b want 111110", cs_n); end
    wait_done(300);
    e = exp_q.pop_front();
    n_cmp++; if (done_cyc - f !== 37) begin n_bad++; $display("FAIL wait_latency: got %0d want 37", done_cyc - f); end
    n_cmp++; if (rx_got !== e)        begin n_bad++; $display("FAIL wait_rx: got %h want %h", rx_got, e); end
    step();
    step();
  endtask

  task automatic test_hold();
    int t;
    logic [7:0] e;
    cs_rel = 0;
    clear_stats(1'b0, 8'h5A);
    exp_q.push_back(8'h5A);
    kick(8'h12, 3'd4, 1'b1, 8'd0, t);
    wait_done(200);
    e = exp_q.pop_front();
    n_cmp++; if (rx_got !== e)      begin n_bad++; $display("FAIL hold_rx1: got %h want %h", rx_got, e); end
    n_cmp++; if (cs_n !== 6'b101111) begin n_bad++; $display("FAIL hold_cs_held: got %b want 101111", cs_n); end
    n_cmp++; if (mosi_cap !== 8'h12) begin n_bad++; $display("FAIL hold_mosi1: got %h want 12", mosi_cap); end
    step();
    clear_stats(1'b0, 8'hC3);
    exp_q.push_back(8'hC3);
    kick(8'h34, 3'd4, 1'b0, 8'd0, t);
    wait_done(200);
    e = exp_q.pop_front();
    step();
    n_cmp++; if (rx_got !== e)       begin n_bad++; $display("FAIL hold_rx2: got %h want %h", rx_got, e); end
    n_cmp++; if (cs_rel !== 1)       begin n_bad++; $display("FAIL hold_releases: got %0d want 1", cs_rel); end
    n_cmp++; if (cs_n !== 6'h3F)     begin n_bad++; $display("FAIL hold_cs_after: got %h want 3f", cs_n); end
    n_cmp++; if (cs_and !== 6'b101111) begin n_bad++; $display("FAIL hold_cs_sel: got %b want 101111", cs_and); end
    step();
  endtask

  task automatic test_ignore_start();
    int t;
    logic [7:0] e;
    clear_stats(1'b1, 8'h00);
    exp_q.push_back(8'h3C);
    kick(8'h3C, 3'd3, 1'b0, 8'd3, t);
    for (int k = 0; k < 200 && rises < 3; k++) step();
    tx_data = 8'hFF;
    cs_sel  = 3'd1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(300);
    e = exp_q.pop_front();
    for (int k = 0; k < 40; k++) step();
    n_cmp++; if (done_cnt !== 1)       begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc - t !== 73)  begin n_bad++; $display("FAIL ign_latency: got %0d want 73", done_cyc - t); end
    n_cmp++; if (rx_got !== e)         begin n_bad++; $display("FAIL ign_rx: got %h want %h", rx_got, e); end
    n_cmp++; if (hi_min !== 4 || hi_max !== 4) begin n_bad++; $display("FAIL ign_high_phase: got %0d..%0d want 4..4", hi_min, hi_max); end
    n_cmp++; if (lo_min !== 4 || lo_max !== 4) begin n_bad++; $display("FAIL ign_low_phase: got %0d..%0d want 4..4", lo_min, lo_max); end
    n_cmp++; if (cs_and !== 6'b110111) begin n_bad++; $display("FAIL ign_cs: got %b want 110111", cs_and); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL ign_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [7:0] e;
    clear_stats(1'b1, 8'h00);
    exp_q.push_back(8'h9E);
    kick(8'h9E, 3'd1, 1'b0, 8'd0, t);
    for (int k = 0; k < 200 && rises < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    n_cmp++; if (cs_n !== 6'h3F)     begin n_bad++; $display("FAIL rmid_cs_n: got %h want 3f", cs_n); end
    n_cmp++; if (sclk !== 1'b0)      begin n_bad++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)      begin n_bad++; $display("FAIL rmid_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (rx_data !== 8'h00)  begin n_bad++; $display("FAIL rmid_rx: got %h want 00", rx_data); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, IDLE); end
    clear_stats(1'b1, 8'h00);
    exp_q.push_back(8'h3C);
    kick(8'h3C, 3'd5, 1'b0, 8'd0, t);
    wait_done(200);
    e = exp_q.pop_front();
    n_cmp++; if (done_cyc - t !== 19)  begin n_bad++; $display("FAIL rmid_latency: got %0d want 19", done_cyc - t); end
    n_cmp++; if (rx_got !== e)         begin n_bad++; $display("FAIL rmid_rx_after: got %h want %h", rx_got, e); end
    n_cmp++; if (cs_and !== 6'b011111) begin n_bad++; $display("FAIL rmid_cs_after: got %b want 011111", cs_and); end
    step();
    step();
  endtask

  task automatic test_bad_sel();
    int t;
    logic [7:0] e;
    clear_stats(1'b0, 8'hFF);
    exp_q.push_back(8'hFF);
    kick(8'hFF, 3'd7, 1'b0, 8'd0, t);
    wait_done(200);
    e = exp_q.pop_front();
    for (int k = 0; k < 10; k++) step();
    n_cmp++; if (cs_and !== 6'h3F)    begin n_bad++; $display("FAIL bad_sel_cs: got %h want 3f", cs_and); end
    n_cmp++; if (rises !== 8)         begin n_bad++; $display("FAIL bad_sel_rises: got %0d want 8", rises); end
    n_cmp++; if (rx_got !== e)        begin n_bad++; $display("FAIL bad_sel_rx: got %h want %h", rx_got, e); end
    n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL bad_sel_done: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc - t !== 19) begin n_bad++; $display("FAIL bad_sel_latency: got %0d want 19", done_cyc - t); end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_data  = '0;
    cs_sel   = '0;
    cs_hold  = 1'b0;
    cfg_div  = '0;
    mem_busy = 1'b0;
    miso     = 1'b0;
    cs_rel   = 0;
    clear_stats(1'b1, 8'h00);

    test_reset();
    test_basic();
    test_wait_bus();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_bad_sel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_periph_engine.md
Name: spi_periph_engine

Overview:
Byte-wide SPI master that drives the six peripheral chip selects (ADC, DAC, UART, ETH, GPIO, FLASH) on the shared SPI bus. It sits inside the interconnect hub's peripheral path, downstream of the hub's SPI register block. It produces the spi_periph_sclk, spi_periph_mosi and spi_periph_cs_n signals that the top level muxes against the SPI memory controller. It never starts a byte while the memory engine owns the bus.

Parameters:
NUM_CS, 6, number of chip-select lines; cs_n index map is fixed in the package.
DIV_W, 8, width of the clock-divider configuration.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to transfer one byte; honoured only when busy=0
tx_data  in  8  byte to send, MSB first; sampled on the accept cycle
cs_sel  in  3  target chip-select index; sampled on the accept cycle
cs_hold  in  1  1 = keep CS asserted after this byte; sampled on the accept cycle
cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles; sampled on the accept cycle
mem_busy  in  1  SPI memory engine owns the bus
miso  in  1  shared MISO
sclk  out  1  SPI clock
mosi  out  1  SPI data out
cs_n  out  NUM_CS  active-low chip selects
busy  out  1  engine owns the bus or is waiting for it; hub stalls memory requests while high
done  out  1  one-cycle pulse at byte completion
rx_data  out  8  received byte; updated in the same cycle as done

Behaviour:
- All outputs are registered. Reset values: sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, rx_data=0x00, state=IDLE.
- States are IDLE, WAIT_BUS, CS_SETUP, SHIFT, CS_END and DONE.
- IDLE: start=1 is accepted and tx_data, cs_sel, cs_hold and cfg_div are latched.
  - If mem_busy=1, the next state is WAIT_BUS.
  - Otherwise the next state is CS_SETUP.
  - busy goes to 1 in the cycle after accept.
- WAIT_BUS: sclk, mosi and cs_n are unchanged. Move to CS_SETUP in the first cycle mem_busy=0.
- CS_SETUP:
  - cs_n[cs_sel]=0; if cs_sel>=NUM_CS, no CS is asserted but the byte is still clocked.
  - mosi=tx_data[7].
  - Lasts cfg_div+1 cycles.
- SHIFT:
  - 16 half-periods of cfg_div+1 cycles each, mode 0.
  - sclk rises on odd half-periods and MISO is sampled on each rising edge.
  - sclk falls on even half-periods and the next MOSI bit is driven on each falling edge.
  - Exactly 8 rising edges; sclk ends at 0.
- CS_END: lasts cfg_div+1 cycles. If cs_hold=0, cs_n returns to all 1 on entry; if cs_hold=1, CS stays low.
- DONE: done=1 and rx_data is updated in this cycle; busy returns to 0 in the next cycle; next state is IDLE.
- Latency with mem_busy=0: if the accept is at cycle T, done=1 at cycle T+18*(cfg_div+1)+1. For cfg_div=0 that is T+19.
- Held CS:
  - A new start with the same cs_sel keeps CS low with no glitch.
  - A start with a different cs_sel releases the held CS on the accept cycle and asserts the new one in CS_SETUP.
- start while busy=1 is ignored and not queued.
- mem_busy rising after CS_SETUP is ignored by the engine. The hub guarantees that no memory request is issued while busy=1.
- Reset in any state takes effect at the next edge with the reset values above. A held CS is also released.
- The divider counter reloads on every phase change, so cfg_div=0 gives sclk=clk/2.

Optional Feature:
SPI_PERIPH_MODE_EN
- Defined: adds an input port cfg_mode[1:0] = {CPOL, CPHA}, latched on accept.
  - CPOL sets the sclk idle level, including the reset value of sclk when the registered mode defaults to 0.
  - CPHA=1 shifts MOSI on the leading edge and samples on the trailing edge.
  - Edge count and latency are unchanged.
- Undefined: the cfg_mode port is absent and the engine is mode 0 only.

Decomposition:
- Package neander_spi_pkg contains:
  - the state enum spi_periph_state_t;
  - the CS index constants CS_ADC=0, CS_DAC=1, CS_UART=2, CS_ETH=3, CS_GPIO=4, CS_FLASH=5;
  - the constant SPI_BITS=8.
- One sub-module, spi_clk_divider: a reloadable down-counter that outputs a one-cycle phase tick every cfg_div+1 cycles. It is cleared on state entry.

Test Plan:
1. cfg_div=0, cs_sel=2, tx=0xA5, miso looped from mosi -> cs_n=6'b111011 during the transfer; 8 sclk rising edges; mosi bits 1,0,1,0,0,1,0,1; done at T+19; rx_data=0xA5; cs_n=6'h3F after.
2. mem_busy=1 for 10 cycles around the start, cs_sel=0 -> busy=1 from T+1; cs_n stays 6'h3F and sclk stays 0 while mem_busy=1; CS_SETUP begins the cycle after mem_busy falls; done at 18*(cfg_div+1)+1 cycles after that.
3. cs_sel=4, cs_hold=1, two bytes 0x12 then 0x34, second byte with cs_hold=0 -> cs_n[4] stays 0 continuously between bytes; cs_n=6'h3F after the second byte's CS_END; rx_data matches miso stimulus.
4. cfg_div=3 with a start pulse mid-SHIFT -> the extra start is ignored; exactly one done pulse; sclk high and low phases each 4 cycles; done at T+73.
5. reset=1 during the 5th bit of SHIFT -> next cycle cs_n=6'h3F, sclk=0, mosi=0, busy=0, rx_data=0x00; a new start after reset completes normally.
6. cs_sel=7, tx=0xFF, miso=1 -> cs_n=6'h3F for the whole transfer; 8 sclk edges; rx_data=0xFF; one done pulse.
